fl_release_walker: RTL and testbench

//  Returns a finished frame's block chain to the free list. Accepts release commands
//  (head block index + block count) from the egress scheduler. Walks the link table
//  one block at a time and drives the free list's free request port.

---
 rtl/fl_release_walker.sv | 175 +++++++++++++++++
 tb/tb_fl_release_walker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fl_release_walker.sv
// Release walker: pops frame-release commands and walks each block chain through the link table,
// issuing one free per block. Optional macro FL_REL_CHECK_EN enables null-link chain checking.
module fl_release_walker #(
  parameter int NUM_BLOCKS = 4096,
  parameter int MAX_BLKS   = 32,
  parameter int CMD_DEPTH  = 4,
  localparam int IDX_W     = $clog2(NUM_BLOCKS),
  localparam int CNT_W     = $clog2(MAX_BLKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rel_valid_i,
  output logic             rel_ready_o,
  input  logic [IDX_W-1:0] rel_head_idx_i,
  input  logic [CNT_W-1:0] rel_nblks_i,
  output logic             link_rd_en_o,
  output logic [IDX_W-1:0] link_rd_idx_o,
  input  logic [IDX_W-1:0] link_rd_data_i,
  output logic             free_req_o,
  output logic [IDX_W-1:0] free_block_idx_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [15:0]      err_cnt_o
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int FP_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FREE, S_WAIT} state_t;

  state_t           r_state;
  logic [FP_W-1:0]  r_wptr, r_rptr;
  logic             r_ready;
  logic [IDX_W-1:0] r_headMem  [CMD_DEPTH];
  logic [CNT_W-1:0] r_nblksMem [CMD_DEPTH];
  logic [IDX_W-1:0] r_cur;
  logic [CNT_W-1:0] r_rem;
  logic             r_freeReq;
  logic [IDX_W-1:0] r_freeIdx;
  logic             r_linkRdEn;
  logic [IDX_W-1:0] r_linkRdIdx;
  logic             r_busy;

  logic             w_push, w_pop, w_empty;
  logic [FP_W-1:0]  w_wptrNext, w_rptrNext, w_cntNext;
  logic [CNT_W-1:0] w_nblksClamp;
  logic [IDX_W-1:0] w_popHead;
  logic [CNT_W-1:0] w_popNblks;
  logic             w_headErr, w_linkErr;
  logic             w_popStart, w_walkNext;

  assign w_push     = rel_valid_i & r_ready;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_wptrNext = r_wptr + {{PTR_W{1'b0}}, w_push};
  assign w_rptrNext = r_rptr + {{PTR_W{1'b0}}, w_pop};
  assign w_cntNext  = w_wptrNext - w_rptrNext;

  assign w_nblksClamp = (rel_nblks_i > CNT_W'(MAX_BLKS)) ? CNT_W'(MAX_BLKS) : rel_nblks_i;
  assign w_popHead    = r_headMem[r_rptr[PTR_W-1:0]];
  assign w_popNblks   = r_nblksMem[r_rptr[PTR_W-1:0]];

`ifdef FL_REL_CHECK_EN
  assign w_headErr = (w_popHead == '0);
  assign w_linkErr = (link_rd_data_i == '0);
`else
  assign w_headErr = 1'b0;
  assign w_linkErr = 1'b0;
`endif

  // A zero-length or rejected command is dropped at pop without leaving IDLE.
  assign w_popStart = w_pop & (w_popNblks != '0) & ~w_headErr;
  assign w_walkNext = w_popStart
                    | ((r_state == S_FREE) & (r_rem > CNT_W'(1)))
                    | ((r_state == S_WAIT) & ~w_linkErr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_wptr  <= w_wptrNext;
      r_rptr  <= w_rptrNext;
      r_ready <= (w_cntNext != FP_W'(CMD_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_headMem[r_wptr[PTR_W-1:0]]  <= rel_head_idx_i;
      r_nblksMem[r_wptr[PTR_W-1:0]] <= w_nblksClamp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_rem       <= '0;
      r_freeReq   <= 1'b0;
      r_freeIdx   <= '0;
      r_linkRdEn  <= 1'b0;
      r_linkRdIdx <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_freeReq  <= 1'b0;
      r_linkRdEn <= 1'b0;
      r_busy     <= (w_cntNext != '0) | w_walkNext;
      case (r_state)
        S_IDLE: begin
          if (w_popStart) begin
            r_cur   <= w_popHead;
            r_rem   <= w_popNblks;
            r_state <= S_FREE;
          end
        end
        S_FREE: begin
          r_freeReq <= 1'b1;
          r_freeIdx <= r_cur;
          r_rem     <= r_rem - CNT_W'(1);
          if (r_rem > CNT_W'(1)) begin
            r_linkRdEn  <= 1'b1;
            r_linkRdIdx <= r_cur;
            r_state     <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (w_linkErr) begin
            r_state <= S_IDLE;
          end else begin
            r_cur   <= link_rd_data_i;
            r_state <= S_FREE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FL_REL_CHECK_EN
  logic        r_err;
  logic [15:0] r_errCnt;
  logic        w_errPulse;

  assign w_errPulse = (w_pop & (w_popNblks != '0) & w_headErr)
                    | ((r_state == S_WAIT) & w_linkErr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_errCnt <= '0;
    end else begin
      r_err <= w_errPulse;
      if (w_errPulse && (r_errCnt != 16'hFFFF)) r_errCnt <= r_errCnt + 16'd1;
    end
  end

  assign err_o     = r_err;
  assign err_cnt_o = r_errCnt;
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = 16'h0000;
`endif

  assign rel_ready_o      = r_ready;
  assign link_rd_en_o     = r_linkRdEn;
  assign link_rd_idx_o    = r_linkRdIdx;
  assign free_req_o       = r_freeReq;
  assign free_block_idx_o = r_freeIdx;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_fl_release_walker.sv
// Scoreboard bench for fl_release_walker: a chain-walking reference model fills expected
// free/link-read queues at command acceptance; a negedge monitor pops and compares.
module tb_fl_release_walker;

  localparam int NUM_BLOCKS = 4096;
  localparam int MAX_BLKS   = 32;
  localparam int CMD_DEPTH  = 4;
  localparam int IDX_W      = 12;
  localparam int CNT_W      = 6;
`ifdef FL_REL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             rel_valid_i;
  logic             rel_ready_o;
  logic [IDX_W-1:0] rel_head_idx_i;
  logic [CNT_W-1:0] rel_nblks_i;
  logic             link_rd_en_o;
  logic [IDX_W-1:0] link_rd_idx_o;
  logic [IDX_W-1:0] link_rd_data_i;
  logic             free_req_o;
  logic [IDX_W-1:0] free_block_idx_o;
  logic             busy_o;
  logic             err_o;
  logic [15:0]      err_cnt_o;

  fl_release_walker #(
    .NUM_BLOCKS(NUM_BLOCKS), .MAX_BLKS(MAX_BLKS), .CMD_DEPTH(CMD_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .rel_valid_i(rel_valid_i), .rel_ready_o(rel_ready_o),
    .rel_head_idx_i(rel_head_idx_i), .rel_nblks_i(rel_nblks_i),
    .link_rd_en_o(link_rd_en_o), .link_rd_idx_o(link_rd_idx_o),
    .link_rd_data_i(link_rd_data_i),
    .free_req_o(free_req_o), .free_block_idx_o(free_block_idx_o),
    .busy_o(busy_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Link table model: data is only meaningful while the strobe is up, otherwise garbage.
  logic [IDX_W-1:0] linkTab [NUM_BLOCKS];
  logic [IDX_W-1:0] junk = '0;
  always @(negedge clk) junk <= IDX_W'($urandom);
  assign link_rd_data_i = link_rd_en_o ? linkTab[link_rd_idx_o] : junk;

  int freeQ[$];
  int linkQ[$];
  int freeCycQ[$];
  int nChecks = 0;
  int nErrors = 0;
  int expErrCnt = 0;
  int errPulses = 0;
  int lastAccCyc = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: follows the chain through the link table by the release rules.
  task automatic modelPush(input int head, input int n);
    int nc;
    int cur;
    int nxt;
    nc  = (n > MAX_BLKS) ? MAX_BLKS : n;
    cur = head;
    if (nc == 0) return;
    if (CHECK && head == 0) begin
      expErrCnt++;
      return;
    end
    for (int k = 0; k < nc; k++) begin
      freeQ.push_back(cur);
      if (k == nc - 1) break;
      linkQ.push_back(cur);
      nxt = int'(linkTab[cur]);
      if (CHECK && nxt == 0) begin
        expErrCnt++;
        break;
      end
      cur = nxt;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (free_req_o) begin
        freeCycQ.push_back(cyc);
        if (freeQ.size() == 0) checkOutput("unexpected_free", int'(free_block_idx_o), -1);
        else checkOutput("free_idx", int'(free_block_idx_o), freeQ.pop_front());
      end
      if (link_rd_en_o) begin
        if (linkQ.size() == 0) checkOutput("unexpected_link_rd", int'(link_rd_idx_o), -1);
        else checkOutput("link_rd_idx", int'(link_rd_idx_o), linkQ.pop_front());
      end
      if (err_o) errPulses++;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input int head, input int n);
    int waitCyc;
    waitCyc = 0;
    rel_head_idx_i = IDX_W'(head);
    rel_nblks_i    = CNT_W'(n);
    rel_valid_i    = 1'b1;
    while (!rel_ready_o && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!rel_ready_o) begin
      checkOutput("ready_timeout", int'(rel_ready_o), 1);
      rel_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    modelPush(head, n);
    @(negedge clk);
    lastAccCyc  = cyc;
    rel_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int k;
    k = 0;
    while ((busy_o || freeQ.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain_free_queue", freeQ.size(), 0);
    checkOutput("drain_link_queue", linkQ.size(), 0);
    checkOutput("drain_busy", int'(busy_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int maxGap;
    int h;
    rst = 1'b1;
    rel_valid_i = 1'b0;
    rel_head_idx_i = '0;
    rel_nblks_i = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) linkTab[i] = IDX_W'($urandom_range(NUM_BLOCKS - 1, 1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("reset_ready", int'(rel_ready_o), 1);
    checkOutput("reset_free_req", int'(free_req_o), 0);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_err_cnt", int'(err_cnt_o), 0);
    checkOutput("reset_link_rd", int'(link_rd_en_o), 0);

    // Three-block chain 5 -> 9 -> 2 with exact free timing
    linkTab[5] = 12'd9;
    linkTab[9] = 12'd2;
    freeCycQ.delete();
    applyStimulus(5, 3);
    acc = lastAccCyc;
    waitIdle(50);
    checkOutput("chain3_free_count", freeCycQ.size(), 3);
    for (int k = 0; k < 3; k++)
      checkOutput("chain3_free_cycle", (k < freeCycQ.size()) ? freeCycQ[k] - acc : -1, 2 * (k + 1));

    // 32-block chain in flight, then four queued commands fill the FIFO
    freeCycQ.delete();
    applyStimulus($urandom_range(NUM_BLOCKS - 1, 1), 32);
    for (int k = 0; k < 4; k++) applyStimulus($urandom_range(NUM_BLOCKS - 1, 1), $urandom_range(8, 1));
    checkOutput("ready_low_when_full", int'(rel_ready_o), 0);
    waitIdle(400);
    maxGap = 0;
    for (int k = 1; k < freeCycQ.size(); k++)
      if (freeCycQ[k] - freeCycQ[k - 1] > maxGap) maxGap = freeCycQ[k] - freeCycQ[k - 1];
    checkOutput("backtoback_max_gap", maxGap, 2);
    checkOutput("ready_after_drain", int'(rel_ready_o), 1);

    // Zero-length command is dropped; single-block command frees once
    freeCycQ.delete();
    applyStimulus($urandom_range(NUM_BLOCKS - 1, 1), 0);
    @(negedge clk);
    checkOutput("nblks0_busy_after_1", int'(busy_o), 0);
    waitIdle(20);
    checkOutput("nblks0_no_free", freeCycQ.size(), 0);
    applyStimulus(7, 1);
    waitIdle(20);
    checkOutput("nblks1_free_count", freeCycQ.size(), 1);

    // Link to null index: error path with the check enabled, plain free otherwise
    linkTab[4] = 12'd0;
    applyStimulus(4, 3);
    waitIdle(50);
    checkOutput("null_link_err_cnt", int'(err_cnt_o), expErrCnt);
    checkOutput("null_link_err_pulses", errPulses, expErrCnt);

    // Reset during WAIT of a 10-block chain
    freeCycQ.delete();
    do h = $urandom_range(NUM_BLOCKS - 1, 5); while (linkTab[h] == '0);
    applyStimulus(h, 10);
    for (int k = 0; k < 40 && !(freeCycQ.size() >= 2 && link_rd_en_o); k++) @(negedge clk);
    checkOutput("reach_wait_state", int'(link_rd_en_o), 1);
    #2;
    rst = 1'b1;
    freeQ.delete();
    linkQ.delete();
    expErrCnt = 0;
    errPulses = 0;
    @(negedge clk);
    checkOutput("midreset_free_req", int'(free_req_o), 0);
    checkOutput("midreset_link_rd", int'(link_rd_en_o), 0);
    checkOutput("midreset_busy", int'(busy_o), 0);
    checkOutput("midreset_ready", int'(rel_ready_o), 1);
    rst = 1'b0;
    freeCycQ.delete();
    repeat (25) @(negedge clk);
    checkOutput("post_reset_no_frees", freeCycQ.size(), 0);
    checkOutput("post_reset_err_cnt", int'(err_cnt_o), 0);

    // Randomized commands: occasional null heads, zero lengths and over-long counts
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      applyStimulus(($urandom_range(9, 0) == 0) ? 0 : $urandom_range(NUM_BLOCKS - 1, 1),
                    $urandom_range(40, 0));
    end
    waitIdle(4000);
    checkOutput("random_err_cnt", int'(err_cnt_o), expErrCnt);
    checkOutput("random_err_pulses", errPulses, expErrCnt);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
